// File: rtl/mdv_block_parser.sv
// Microdrive block parser: splits the replayed byte stream into sector-header and
// data-block records, verifies QL checksums and publishes sector/file/block numbers.
module mdv_block_parser #(
  parameter int unsigned NAME_LEN  = 10,
  parameter int unsigned DATA_LEN  = 512,
  parameter logic [15:0] CSUM_INIT = 16'h0F0F
) (
  input  logic       mdv_clk,
  input  logic       reset,
  input  logic       gap,
  input  logic       rx_ready,
  input  logic [7:0] din,
  output logic [7:0] sector,
  output logic       sector_valid,
  output logic [7:0] file_num,
  output logic [7:0] block_num,
  output logic       hdr_done,
  output logic       blk_done,
  output logic       csum_ok,
  output logic [9:0] byte_idx,
  output logic       in_data
);

  typedef enum logic [2:0] {
    StWaitGap,
    StGap,
    StFirst,
    StHdr,
    StBhdr,
    StData
  } state_e;

  localparam logic [9:0] HdrLoIdx = 10'(NAME_LEN + 2);
  localparam logic [9:0] HdrHiIdx = 10'(NAME_LEN + 3);
  localparam logic [9:0] DataLast = 10'(DATA_LEN - 1);
  localparam logic [9:0] DataLoIdx = 10'(DATA_LEN);
  localparam logic [9:0] DataHiIdx = 10'(DATA_LEN + 1);

  state_e      r_state;
  logic [15:0] r_acc;
  logic [7:0]  r_lo;
  logic [7:0]  r_tmp_a;
  logic [7:0]  r_tmp_b;
  logic [7:0]  r_sector;
  logic        r_sector_valid;
  logic [7:0]  r_file_num;
  logic [7:0]  r_block_num;
  logic        r_hdr_done;
  logic        r_blk_done;
  logic        r_csum_ok;
  logic [9:0]  r_byte_idx;
  logic        r_in_data;

  logic        w_accept;
  logic        w_in_record;
  logic [15:0] w_acc_sum;
  logic        w_match;

  // gap beats rx_ready when both arrive together
  assign w_accept    = rx_ready & ~gap;
  assign w_in_record = (r_state == StFirst) || (r_state == StHdr) ||
                       (r_state == StBhdr) || (r_state == StData);
  assign w_acc_sum   = r_acc + {8'h00, din};
  assign w_match     = ({din, r_lo} == r_acc);

  always_ff @(posedge mdv_clk or posedge reset) begin
    if (reset) begin
      r_state        <= StWaitGap;
      r_acc          <= 16'h0000;
      r_lo           <= 8'h00;
      r_tmp_a        <= 8'h00;
      r_tmp_b        <= 8'h00;
      r_sector       <= 8'h00;
      r_sector_valid <= 1'b0;
      r_file_num     <= 8'h00;
      r_block_num    <= 8'h00;
      r_hdr_done     <= 1'b0;
      r_blk_done     <= 1'b0;
      r_csum_ok      <= 1'b0;
      r_byte_idx     <= 10'd0;
      r_in_data      <= 1'b0;
    end else begin
      r_hdr_done <= 1'b0;
      r_blk_done <= 1'b0;
      if (gap && w_in_record) begin
        // Aborted record: no pulse, published values stay as they were
        r_state   <= StGap;
        r_in_data <= 1'b0;
      end else begin
        case (r_state)
          StWaitGap: begin
            if (gap) r_state <= StGap;
          end
          StGap: begin
            if (!gap) begin
              r_state    <= StFirst;
              r_acc      <= CSUM_INIT;
              r_byte_idx <= 10'd0;
            end
          end
          StFirst: begin
            if (w_accept) begin
              r_acc      <= w_acc_sum;
              r_byte_idx <= 10'd1;
              if (din == 8'hFF) begin
                r_state <= StHdr;
              end else begin
                r_tmp_a <= din;
                r_state <= StBhdr;
              end
            end
          end
          StHdr: begin
            if (w_accept) begin
              r_byte_idx <= r_byte_idx + 10'd1;
              if (r_byte_idx == 10'd1) begin
                r_tmp_b <= din;
                r_acc   <= w_acc_sum;
              end else if (r_byte_idx == HdrLoIdx) begin
                r_lo <= din;
              end else if (r_byte_idx == HdrHiIdx) begin
                r_hdr_done     <= 1'b1;
                r_csum_ok      <= w_match;
                r_sector_valid <= w_match;
                if (w_match) r_sector <= r_tmp_b;
                r_state <= StWaitGap;
              end else begin
                r_acc <= w_acc_sum;
              end
            end
          end
          StBhdr: begin
            if (w_accept) begin
              r_byte_idx <= r_byte_idx + 10'd1;
              if (r_byte_idx == 10'd1) begin
                r_tmp_b <= din;
                r_acc   <= w_acc_sum;
              end else if (r_byte_idx == 10'd2) begin
                r_lo <= din;
              end else begin
                if (w_match) begin
                  r_file_num  <= r_tmp_a;
                  r_block_num <= r_tmp_b;
                  r_acc       <= CSUM_INIT;
                  r_byte_idx  <= 10'd0;
                  r_in_data   <= 1'b1;
                  r_state     <= StData;
                end else begin
                  r_blk_done <= 1'b1;
                  r_csum_ok  <= 1'b0;
                  r_state    <= StWaitGap;
                end
              end
            end
          end
          StData: begin
            if (w_accept) begin
              r_byte_idx <= r_byte_idx + 10'd1;
              if (r_byte_idx < DataLoIdx) begin
                r_acc <= w_acc_sum;
                if (r_byte_idx == DataLast) r_in_data <= 1'b0;
              end else if (r_byte_idx == DataLoIdx) begin
                r_lo <= din;
              end else if (r_byte_idx == DataHiIdx) begin
                r_blk_done <= 1'b1;
                r_csum_ok  <= w_match;
                r_state    <= StWaitGap;
              end
            end
          end
          default: r_state <= StWaitGap;
        endcase
      end
    end
  end

  assign sector       = r_sector;
  assign sector_valid = r_sector_valid;
  assign file_num     = r_file_num;
  assign block_num    = r_block_num;
  assign hdr_done     = r_hdr_done;
  assign blk_done     = r_blk_done;
  assign csum_ok      = r_csum_ok;
  assign byte_idx     = r_byte_idx;
  assign in_data      = r_in_data;

endmodule

// File: doc/mdv_block_parser.md
Name: mdv_block_parser

Overview:
- Sits directly downstream of the microdrive replay stage, in the mdv_clk domain.
- Consumes the replayed byte stream (gap, per-byte rx strobe, byte data), splits it into sector-header and data-block records, and verifies QL checksums.
- Publishes the current sector number, file/block numbers and checksum status to the ZX8302 status logic and to the OSD/debug registers.

Parameters:
- NAME_LEN, 10: medium-name bytes in a sector header.
- DATA_LEN, 512: payload bytes in a data block.
- CSUM_INIT, 16'h0F0F: QL checksum seed.

Ports:
- mdv_clk, input, 1: microdrive bit clock (200 kHz).
- reset, input, 1: asynchronous, active-high.
- gap, input, 1: high during tape gap or when no medium is present.
- rx_ready, input, 1: one-cycle strobe; din is valid in the same cycle.
- din, input, 8: received byte.
- sector, output, 8: sector number from the last good header.
- sector_valid, output, 1: sector holds a checksum-verified value.
- file_num, output, 8: file number from the last good block header.
- block_num, output, 8: block number from the last good block header.
- hdr_done, output, 1: one-cycle pulse at the end of a header record.
- blk_done, output, 1: one-cycle pulse at the end of a data record.
- csum_ok, output, 1: result of the last completed record; valid while hdr_done or blk_done is high, held afterwards.
- byte_idx, output, 10: index of the next expected byte within the current record.
- in_data, output, 1: high while payload bytes are being consumed.

Behaviour:
- Clock and reset: clock mdv_clk; reset is asynchronous, active-high. All outputs reset to 0, and the FSM resets to WAIT_GAP.
- Internal state:
  - acc: 16-bit running sum, wraps modulo 2^16.
  - lo: stored checksum low byte.
  - tmp_a / tmp_b: staging bytes.
- Byte acceptance: a byte is accepted only in a cycle with rx_ready=1 and gap=0. When rx_ready=1 and gap=1 in the same cycle, gap wins and the byte is ignored.
- FSM states:
  - WAIT_GAP: wait for gap=1, then go to GAP.
  - GAP: on gap=0 go to FIRST; set acc=CSUM_INIT, byte_idx=0.
  - FIRST: on the first accepted byte b, set acc+=b, byte_idx=1.
    - If b==8'hFF, go to HDR.
    - Otherwise, tmp_a=b (file number) and go to BHDR.
  - HDR:
    - Byte 1: sector candidate; add to acc.
    - Bytes 2..NAME_LEN+1: add to acc.
    - Byte NAME_LEN+2: checksum low byte, store it and do not add.
    - Byte NAME_LEN+3: checksum high byte. Compare {high,lo} with acc, pulse hdr_done, set csum_ok. If equal, sector=candidate and sector_valid=1; otherwise sector_valid=0 and sector is held. Go to WAIT_GAP.
  - BHDR:
    - Byte 1: block number, add to acc.
    - Bytes 2..3: checksum low/high. On match, file_num=tmp_a and block_num=tmp_b.
    - On mismatch, pulse blk_done with csum_ok=0 and go to WAIT_GAP.
    - On match, go to DATA with acc=CSUM_INIT and byte_idx=0.
  - DATA:
    - in_data=1; sum DATA_LEN bytes.
    - Then the checksum low/high bytes follow (in_data=0 during these).
    - After the high byte, pulse blk_done with csum_ok=(match) and go to WAIT_GAP.
    - Trailing bytes before the next gap are ignored.
- byte_idx: increments per accepted byte and resets to 0 at each record start. It is 10 bits and must not overflow within DATA_LEN+2.
- Gap mid-record: gap=1 in any state other than WAIT_GAP/GAP aborts the record. There is no done pulse, outputs are held, in_data=0, and the FSM goes straight to GAP.
- Gap with no medium: gap held high indefinitely keeps the FSM in GAP with no pulses.
- Reset mid-record: all outputs and state are cleared immediately. The first record after reset is only parsed after a full gap has been seen.
- Done pulses: hdr_done and blk_done are never both high, and each is exactly one mdv_clk cycle.

Test Plan:
- Header with sector 8'h2A, name "QLDISK    ", correct checksum (0x0F0F + sum of FF, 2A and name bytes, sent low byte first) -> hdr_done pulse, csum_ok=1, sector=8'h2A, sector_valid=1.
- Same header with checksum high byte flipped -> hdr_done with csum_ok=0, sector_valid=0, sector still holds the previous value.
- Block header (file 8'h03, block 8'h05, good checksum) then 512 bytes 0..255,0..255 with correct checksum -> in_data high for exactly 512 accepted bytes, blk_done with csum_ok=1, file_num=3, block_num=5.
- gap asserted after 100 payload bytes -> no blk_done, in_data drops the next cycle; the following header parses normally.
- rx_ready coincident with gap=1, and bytes arriving before the first gap after reset -> ignored, byte_idx stays 0, no pulses.
- reset asserted mid-DATA -> all outputs 0 immediately, FSM in WAIT_GAP; a subsequent full gap plus header yields a correct hdr_done.
